// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage and dmem_lsu.
// master = requester, slave = data memory.
interface dmem_lsu_if #(
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size,
      output req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size,
      input  req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-lane data memory with load/store aligner.
// Zero-fills the array after reset when CLEAR_ON_RESET is set.
module dmem_lsu #(
   parameter int ADDR_W         = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic      clk,
   input  logic      rst,
   dmem_lsu_if.slave bus,
   output logic      init_done
);
   localparam int IW    = ADDR_W - 2;
   localparam int DEPTH = 2 ** IW;

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam state_t RST_ST = CLEAR_ON_RESET ? S_INIT : S_RUN;

   state_t        state, state_nx;
   logic [IW-1:0] cnt, cnt_nx;
   logic          clr;

   logic          acc;
   logic          mis;
   logic [IW-1:0] widx;
   logic [1:0]    lane;
   logic [3:0]    be;
   logic [31:0]   wword;
   logic [31:0]   rword;
   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic [31:0]   ldata;
   logic          sx;

   logic [IW-1:0] m_idx;
   logic [3:0]    m_we;
   logic [31:0]   m_wd;

   logic [7:0]    mem [4][DEPTH];

   // clear sequencer: one word per cycle, then hand over to RUN
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      clr      = 1'b0;
      case (state)
         S_INIT: begin
            clr    = 1'b1;
            cnt_nx = cnt + IW'(1);
            if (cnt == IW'(DEPTH - 1))
               state_nx = S_RUN;
         end
         S_RUN: ;
         default: state_nx = RST_ST;
      endcase
   end

   // state, clear counter and the registered ready/done flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RST_ST;
         cnt       <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         init_done <= (state_nx == S_RUN);
      end
   end

   assign bus.req_ready = init_done;

   assign acc  = bus.req_valid & bus.req_ready;
   assign widx = bus.req_addr[ADDR_W-1:2];
   assign lane = bus.req_addr[1:0];

   // alignment check, lane enables and store-data replication
   always_comb begin
      mis   = 1'b0;
      be    = 4'b0000;
      wword = bus.req_wdata;
      unique case (1'b1)
         bus.req_size == 2'd0: begin
            be    = 4'b0001 << lane;
            wword = {4{bus.req_wdata[7:0]}};
         end
         bus.req_size == 2'd1: begin
            mis   = lane[0];
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{bus.req_wdata[15:0]}};
         end
         bus.req_size == 2'd2: begin
            mis = |lane;
            be  = 4'b1111;
         end
         default: mis = 1'b1;
      endcase
   end

   // single write port shared by the clear sequence and stores
   always_comb begin
      m_idx = widx;
      m_we  = 4'b0000;
      m_wd  = wword;
      if (clr) begin
         m_idx = cnt;
         m_we  = 4'b1111;
         m_wd  = '0;
      end else if (acc && bus.req_we && !mis) begin
         m_we = be;
      end
   end

   // byte-lane array write
   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++)
         if (m_we[l])
            mem[l][m_idx] <= m_wd[8*l +: 8];
   end

   assign rword = {mem[3][widx], mem[2][widx],
                   mem[1][widx], mem[0][widx]};
   assign bsel  = rword[{lane, 3'b000} +: 8];
   assign hsel  = rword[{lane[1], 4'b0000} +: 16];

   // load aligner: pick lane/half, shift down, extend
   always_comb begin
      ldata = rword;
      sx    = 1'b0;
      case (bus.req_size)
         2'd0: begin
            sx    = ~bus.req_unsigned & bsel[7];
            ldata = {{24{sx}}, bsel};
         end
         2'd1: begin
            sx    = ~bus.req_unsigned & hsel[15];
            ldata = {{16{sx}}, hsel};
         end
         default: ldata = rword;
      endcase
   end

   // registered response, data/err hold when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= acc;
         if (acc) begin
            bus.rsp_err   <= mis;
            bus.rsp_rdata <= (bus.req_we || mis) ? '0 : ldata;
         end
      end
   end
endmodule
